lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store unit for the RV64 core's memory stage, placed directly downstream of the ALU. It takes the ALU's 64-bit result as the effective address, plus store data and a memory-op code, from the execute stage. It then runs one transaction on a simple request/response data-memory port and hands byte-aligned, sign- or zero-extended load data (or a store completion) to write-back. Misaligned accesses never reach memory; they complete with an error flag.

## Interface
Parameters:
- XLEN, 64, data/address width; the only supported value is 64.

Ports:
- clk  in  1  the block's single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a memory op.
- in_ready  out  1  LSU can accept an op; equals (state==IDLE && !rst).
- in_addr  in  XLEN  effective address; the ALU's add result.
- in_wdata  in  XLEN  store data (rs2), right-aligned.
- in_memop  in  4  [3]=store, [2]=unsigned load, [1:0]=log2 size (0=B,1=H,2=W,3=D).
- mem_req_valid  out  1  request to data memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  in_addr with [2:0] forced to 0.
- mem_wen  out  1  1 = write.
- mem_wdata  out  XLEN  store data shifted to byte lane.
- mem_wmask  out  8  byte-enable mask.
- mem_resp_valid  in  1  read data or write ack valid (one cycle pulse).
- mem_rdata  in  XLEN  raw 8-byte-aligned read data.
- out_valid  out  1  result ready for write-back.
- out_ready  in  1  write-back accepts result.
- out_rdata  out  XLEN  extended load data; 0 for stores.
- out_misalign  out  1  op was misaligned; no memory access was made.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch addr, wdata and memop. Go to DONE with misalign=1 if the address is misaligned for the size (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0); otherwise go to REQ.
- REQ: mem_req_valid=1 and the mem_* fields are driven from the latched values. On mem_req_ready, go to WAIT.
- WAIT: mem_req_valid=0. On mem_resp_valid, capture the response and go to DONE. For loads, capture the extracted data; for stores, capture 0.
- DONE: out_valid=1 and out_rdata/out_misalign are held stable. On out_ready, go to IDLE.
- Lane shift: off = addr[2:0]*8.
- Store data: mem_wdata = in_wdata << off.
- Store mask: mem_wmask = base << addr[2:0], where base = 0x01/0x03/0x0F/0xFF for B/H/W/D.
- Load data: rdata >> off, truncated to the size. It is sign-extended from bit 7/15/31 unless memop[2]=1, in which case it is zero-extended. D ignores memop[2].
- mem_wen=memop[3]. For loads, mem_wdata=0 and mem_wmask=0.
- Store with memop[2]=1: treated as a normal store; memop[2] is ignored.
- mem_resp_valid outside WAIT: ignored.
- Only one transaction is in flight; no new op is accepted until DONE handshakes.

## Timing
- Reset values: state=IDLE, mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, out_valid=0, out_rdata=0, out_misalign=0, in_ready=0 during rst and 1 in the first cycle after rst falls.
- Aligned op, zero-wait memory:
  - accept at cycle 0;
  - mem_req_valid at cycle 1;
  - response at cycle 2 or later (a response is never taken in the request-accept cycle);
  - out_valid at cycle 3.
- Misaligned op: accept at cycle 0, out_valid at cycle 1. mem_req_valid never asserts.
- mem_req_valid, once raised, stays high with stable fields until mem_req_ready.
- out_valid, once raised, stays high with stable data until out_ready.
- Back-to-back: the handshake at DONE returns to IDLE. The next op is accepted one cycle later; there is no bypass.
- rst mid-transaction (any state) returns to IDLE next edge, drops all valids and discards the latched op. Memory is reset on the same rst, so no stale response arrives.

## Test plan
- LB sign: addr=0x8000_0003, memop=0x0, mem_rdata=0x1122_3344_8877_6655 -> out_rdata=0xFFFF_FFFF_FFFF_FF88, mem_addr=0x8000_0000, out_valid at cycle 3 with zero-wait memory.
- LHU zero-extend: addr=0x8000_0006, memop=0x5, same rdata -> out_rdata=0x0000_0000_0000_1122.
- SW lane: addr=0x8000_0004, memop=0xA, wdata=0xDEAD_BEEF_CAFE_BABE -> mem_wen=1, mem_wmask=0xF0, mem_wdata=0xCAFE_BABE_0000_0000, out_rdata=0.
- Misaligned LD: addr=0x8000_0004, memop=0x3 -> out_misalign=1 at cycle 1, mem_req_valid stays 0 throughout.
- Backpressure: mem_req_ready low for 3 cycles, then out_ready low for 2 cycles -> request fields and output held stable, in_ready=0 until the DONE handshake.
- Reset in WAIT: assert rst for 1 cycle while in WAIT -> all outputs return to reset values, and in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bus bundle for the load/store unit: execute-side op, data-memory port and write-back result.
// The master modport is the LSU's view; slave is the surrounding pipeline and memory.
interface lsu_ctrl_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [3:0]      in_memop;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rdata;
  logic            out_misalign;

  modport master (
    input  in_valid, in_addr, in_wdata, in_memop,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_ready,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output out_valid, out_rdata, out_misalign
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_memop,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    output out_ready,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  out_valid, out_rdata, out_misalign
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-transaction load/store unit: aligns store data into byte lanes, extracts and extends
// load data, and short-circuits misaligned ops straight to write-back with an error flag.
module lsu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } stateType;

  stateType        stateReg;
  logic [2:0]      offReg;
  logic [1:0]      sizeReg;
  logic            unsReg;

  logic            memReqValidReg;
  logic [XLEN-1:0] memAddrReg;
  logic            memWenReg;
  logic [XLEN-1:0] memWdataReg;
  logic [7:0]      memWmaskReg;
  logic            outValidReg;
  logic [XLEN-1:0] outRdataReg;
  logic            outMisalignReg;

  logic            misaligned;
  logic [7:0]      baseMask;
  logic [7:0]      storeMask;
  logic [XLEN-1:0] storeShift;
  logic [XLEN-1:0] loadShift;
  logic [XLEN-1:0] loadExt;

  assign bus.in_ready      = (stateReg == IDLE) && !rst;
  assign bus.mem_req_valid = memReqValidReg;
  assign bus.mem_addr      = memAddrReg;
  assign bus.mem_wen       = memWenReg;
  assign bus.mem_wdata     = memWdataReg;
  assign bus.mem_wmask     = memWmaskReg;
  assign bus.out_valid     = outValidReg;
  assign bus.out_rdata     = outRdataReg;
  assign bus.out_misalign  = outMisalignReg;

  // Alignment check and store lane placement work on the incoming op so they can be latched at accept.
  always_comb begin
    misaligned = 1'b0;
    baseMask   = 8'h01;
    case (bus.in_memop[1:0])
      2'd0: begin
        misaligned = 1'b0;
        baseMask   = 8'h01;
      end
      2'd1: begin
        misaligned = bus.in_addr[0];
        baseMask   = 8'h03;
      end
      2'd2: begin
        misaligned = |bus.in_addr[1:0];
        baseMask   = 8'h0F;
      end
      default: begin
        misaligned = |bus.in_addr[2:0];
        baseMask   = 8'hFF;
      end
    endcase
    storeMask  = baseMask << bus.in_addr[2:0];
    storeShift = bus.in_wdata << {bus.in_addr[2:0], 3'b000};
  end

  // Load extraction uses the latched offset/size since the response arrives cycles after accept.
  always_comb begin
    loadShift = bus.mem_rdata >> {offReg, 3'b000};
    loadExt   = loadShift;
    case (sizeReg)
      2'd0: loadExt = {{(XLEN-8){loadShift[7] & ~unsReg}}, loadShift[7:0]};
      2'd1: loadExt = {{(XLEN-16){loadShift[15] & ~unsReg}}, loadShift[15:0]};
      2'd2: loadExt = {{(XLEN-32){loadShift[31] & ~unsReg}}, loadShift[31:0]};
      default: loadExt = loadShift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg       <= IDLE;
      offReg         <= '0;
      sizeReg        <= '0;
      unsReg         <= 1'b0;
      memReqValidReg <= 1'b0;
      memAddrReg     <= '0;
      memWenReg      <= 1'b0;
      memWdataReg    <= '0;
      memWmaskReg    <= '0;
      outValidReg    <= 1'b0;
      outRdataReg    <= '0;
      outMisalignReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.in_valid) begin
            offReg      <= bus.in_addr[2:0];
            sizeReg     <= bus.in_memop[1:0];
            unsReg      <= bus.in_memop[2];
            outRdataReg <= '0;
            if (misaligned) begin
              outMisalignReg <= 1'b1;
              outValidReg    <= 1'b1;
              stateReg       <= DONE;
            end else begin
              outMisalignReg <= 1'b0;
              memReqValidReg <= 1'b1;
              memAddrReg     <= {bus.in_addr[XLEN-1:3], 3'b000};
              memWenReg      <= bus.in_memop[3];
              memWdataReg    <= bus.in_memop[3] ? storeShift : '0;
              memWmaskReg    <= bus.in_memop[3] ? storeMask : 8'h00;
              stateReg       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            memReqValidReg <= 1'b0;
            stateReg       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            outRdataReg <= memWenReg ? '0 : loadExt;
            outValidReg <= 1'b1;
            stateReg    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValidReg <= 1'b0;
            stateReg    <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned loads/stores, misalignment, backpressure and mid-op reset.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(64)) bus ();

  lsu_ctrl #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int compared = 0;
  int mismatched = 0;

  localparam logic [63:0] RDATA = 64'h1122_3344_8877_6655;
  localparam logic [63:0] WDATA = 64'hDEAD_BEEF_CAFE_BABE;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory flow: accept at cycle 0, request at 1, response at 2, result at 3.
  task automatic runOp(input string tag, input logic [63:0] addr, input logic [3:0] memop,
                       input logic [63:0] expAddr, input logic expWen, input logic [63:0] expWdata,
                       input logic [7:0] expMask, input logic [63:0] expRdata);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid      = 1'b1;
    bus.in_addr       = addr;
    bus.in_wdata      = WDATA;
    bus.in_memop      = memop;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, ".req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, ".mem_addr"}, bus.mem_addr, expAddr);
    check({tag, ".mem_wen"}, 64'(bus.mem_wen), 64'(expWen));
    check({tag, ".mem_wdata"}, bus.mem_wdata, expWdata);
    check({tag, ".mem_wmask"}, 64'(bus.mem_wmask), 64'(expMask));
    tick();
    check({tag, ".req_drop"}, 64'(bus.mem_req_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = RDATA;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".out_rdata"}, bus.out_rdata, expRdata);
    check({tag, ".misalign"}, 64'(bus.out_misalign), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".out_drop"}, 64'(bus.out_valid), 64'd0);
    $display("op %s addr=%h memop=%h rdata=%h", tag, addr, memop, bus.out_rdata);
  endtask

  initial begin
    rst                = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_addr        = '0;
    bus.in_wdata       = '0;
    bus.in_memop       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.out_ready      = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst.in_ready", 64'(bus.in_ready), 64'd0);
    check("rst.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst.mem_addr", bus.mem_addr, 64'd0);
    check("rst.mem_wmask", 64'(bus.mem_wmask), 64'd0);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.out_rdata", bus.out_rdata, 64'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", 64'(bus.in_ready), 64'd1);

    // Zero-wait loads and stores
    runOp("LB", 64'h8000_0003, 4'h0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF88);
    runOp("LHU", 64'h8000_0006, 4'h5, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_1122);
    runOp("LBU", 64'h8000_0001, 4'h4, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_0066);
    runOp("LH", 64'h8000_0002, 4'h1, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_8877);
    runOp("LW", 64'h8000_000C, 4'h2, 64'h8000_0008, 1'b0, 64'd0, 8'h00, 64'h0000_0000_1122_3344);
    runOp("LWneg", 64'h8000_0000, 4'h2, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_8877_6655);
    runOp("LD", 64'h8000_0008, 4'h3, 64'h8000_0008, 1'b0, 64'd0, 8'h00, RDATA);
    runOp("LDU", 64'h8000_0010, 4'h7, 64'h8000_0010, 1'b0, 64'd0, 8'h00, RDATA);
    runOp("SB", 64'h8000_0007, 4'h8, 64'h8000_0000, 1'b1, 64'hBE00_0000_0000_0000, 8'h80, 64'd0);
    runOp("SHu", 64'h8000_0002, 4'hD, 64'h8000_0000, 1'b1, 64'hBEEF_CAFE_BABE_0000, 8'h0C, 64'd0);

    // SW with request backpressure, a stray response during REQ, then write-back backpressure
    bus.in_valid      = 1'b1;
    bus.in_addr       = 64'h8000_0004;
    bus.in_wdata      = WDATA;
    bus.in_memop      = 4'hA;
    bus.mem_req_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("SW.req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("SW.mem_addr", bus.mem_addr, 64'h8000_0000);
      check("SW.mem_wen", 64'(bus.mem_wen), 64'd1);
      check("SW.mem_wdata", bus.mem_wdata, 64'hCAFE_BABE_0000_0000);
      check("SW.mem_wmask", 64'(bus.mem_wmask), 64'hF0);
      check("SW.in_ready", 64'(bus.in_ready), 64'd0);
      bus.mem_resp_valid = (i == 1);
      bus.mem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("SW.stray_resp", 64'(bus.out_valid), 64'd0);
    end
    bus.mem_req_ready = 1'b1;
    check("SW.req_hold", 64'(bus.mem_req_valid), 64'd1);
    tick();
    check("SW.req_drop", 64'(bus.mem_req_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("SW.out_valid", 64'(bus.out_valid), 64'd1);
      check("SW.out_rdata", bus.out_rdata, 64'd0);
      check("SW.in_ready_done", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("SW.out_hold", 64'(bus.out_valid), 64'd1);
    tick();
    bus.out_ready = 1'b0;
    check("SW.out_drop", 64'(bus.out_valid), 64'd0);
    check("SW.in_ready_idle", 64'(bus.in_ready), 64'd1);
    $display("op SW addr=80000004 backpressure done");

    // Misaligned LD and LW: result next cycle, memory untouched
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = (i == 0) ? 64'h8000_0004 : 64'h8000_0002;
      bus.in_memop = (i == 0) ? 4'h3 : 4'h2;
      check("MIS.req_c0", 64'(bus.mem_req_valid), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      check("MIS.out_valid", 64'(bus.out_valid), 64'd1);
      check("MIS.misalign", 64'(bus.out_misalign), 64'd1);
      check("MIS.out_rdata", bus.out_rdata, 64'd0);
      check("MIS.req_c1", 64'(bus.mem_req_valid), 64'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("MIS.out_drop", 64'(bus.out_valid), 64'd0);
      check("MIS.req_c2", 64'(bus.mem_req_valid), 64'd0);
      $display("op MIS addr=%h memop=%h misalign flagged", bus.in_addr, bus.in_memop);
    end

    // Reset while waiting for a response
    bus.in_valid      = 1'b1;
    bus.in_addr       = 64'h0000_0010;
    bus.in_memop      = 4'h0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("RW.in_wait", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    tick();
    check("RW.in_ready_rst", 64'(bus.in_ready), 64'd0);
    check("RW.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("RW.mem_addr", bus.mem_addr, 64'd0);
    check("RW.mem_wen", 64'(bus.mem_wen), 64'd0);
    check("RW.out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("RW.in_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    check("RW.no_stale", 64'(bus.out_valid), 64'd0);
    $display("op RST in WAIT recovered");
    runOp("LBpost", 64'h8000_0003, 4'h0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
